// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer and its
// single-step shifter datapath.
package shift_seq_pkg;

   localparam int DATA_W = 16;

   localparam logic [1:0] OP_PASS = 2'b00;
   localparam logic [1:0] OP_LSL  = 2'b01;
   localparam logic [1:0] OP_LSR  = 2'b10;
   localparam logic [1:0] OP_ASR  = 2'b11;

   // Fixed encodings so the state register matches legacy two-bit decodes.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      SHIFT = ST_SHIFT,
      DONE  = ST_DONE
   } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle between the decoder side (master) and the
// shift sequencer (slave).
interface shift_sequencer_if
   import shift_seq_pkg::*;
#(
   parameter int AMT_W = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [1:0]        in_op;
   logic [AMT_W-1:0]  in_amt;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_zero;
   logic              out_neg;

   modport master (
      output in_valid, in_data, in_op, in_amt, out_ready,
      input  in_ready, out_valid, out_data, out_zero, out_neg
   );

   modport slave (
      input  in_valid, in_data, in_op, in_amt, out_ready,
      output in_ready, out_valid, out_data, out_zero, out_neg
   );
endinterface

// File: rtl/shift_sequencer_shifter.sv
// Single-step 16-bit shifter: pass, logical left, logical right or
// arithmetic right by exactly one position.
module shift_sequencer_shifter
   import shift_seq_pkg::*;
(
   input  logic [DATA_W-1:0] data_in,
   input  logic [1:0]        op,
   output logic [DATA_W-1:0] data_out
);

   // NOTE: default assignment first so every path drives data_out and no latch is inferred.
   always_comb begin
      data_out = data_in;
      case (op)
         OP_LSL:  data_out = {data_in[DATA_W-2:0], 1'b0};
         OP_LSR:  data_out = {1'b0, data_in[DATA_W-1:1]};
         OP_ASR:  data_out = {data_in[DATA_W-1], data_in[DATA_W-1:1]};
         default: data_out = data_in;
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: iterates the single-step shifter over a
// working register, then holds the result on a valid/ready output.
module shift_sequencer
   import shift_seq_pkg::*;
#(
   parameter int AMT_W = 4
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   output logic             busy,
   shift_sequencer_if.slave bus
);

   state_t            state;
   logic [DATA_W-1:0] work_reg;
   logic [1:0]        op_reg;
   logic [AMT_W-1:0]  cnt_reg;

   logic [1:0]        shift_op;
   logic [DATA_W-1:0] shift_out;

   // Outside SHIFT the shifter idles as a pass-through; its output is ignored.
   assign shift_op = (state == SHIFT) ? op_reg : OP_PASS;

   shift_sequencer_shifter u_shifter (
      .data_in  (work_reg),
      .op       (shift_op),
      .data_out (shift_out)
   );

   // NOTE: reset sits in the sensitivity list so it acts asynchronously; state updates use <= only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         work_reg <= '0;
         op_reg   <= OP_PASS;
         cnt_reg  <= '0;
      end else if (flush) begin
         state    <= IDLE;
         work_reg <= '0;
         cnt_reg  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  work_reg <= bus.in_data;
                  op_reg   <= bus.in_op;
                  cnt_reg  <= bus.in_amt;
                  if ((bus.in_amt == '0) || (bus.in_op == OP_PASS))
                     state <= DONE;
                  else
                     state <= SHIFT;
               end
            end
            SHIFT: begin
               work_reg <= shift_out;
               cnt_reg  <= cnt_reg - AMT_W'(1);
               // Leaving on the last step keeps the counter from ever wrapping.
               if (cnt_reg == AMT_W'(1))
                  state <= DONE;
            end
            DONE: begin
               if (bus.out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign busy          = (state != IDLE);

   // Flags track work_reg directly; consumers only regard them while out_valid.
   assign bus.out_data  = work_reg;
   assign bus.out_zero  = (work_reg == '0);
   assign bus.out_neg   = work_reg[DATA_W-1];

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus randomized
// requests checked against an arithmetic reference model.
module tb_shift_sequencer;
   import shift_seq_pkg::*;

   logic clk;
   logic reset;
   logic flush;
   logic busy;
   int   n_tests;
   int   n_fail;

   shift_sequencer_if #(.AMT_W(4)) bus ();

   shift_sequencer #(.AMT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .busy  (busy),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: shifting by n single steps equals one n-position shift.
   function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [1:0] op,
                                             input int amt);
      logic [15:0] r;
      case (op)
         2'b01:   r = d << amt;
         2'b10:   r = d >> amt;
         2'b11:   r = 16'($signed(d) >>> amt);
         default: r = d;
      endcase
      return r;
   endfunction

   // Protocol monitor: held result stays stable, and in_ready/out_valid are exclusive.
   logic        prev_hold;
   logic [15:0] prev_data;
   always @(negedge clk) begin
      if (!reset) begin
         check("ready_valid_exclusive", {31'd0, bus.in_ready & bus.out_valid}, 32'd0);
         if (prev_hold && bus.out_valid)
            check("out_data_stable", {16'd0, bus.out_data}, {16'd0, prev_data});
      end
      prev_hold = bus.out_valid & !bus.out_ready & !flush & !reset;
      prev_data = bus.out_data;
   end

   // Issue one request, wait for its result, optionally stall, then drain it.
   task automatic do_req(input logic [15:0] d, input logic [1:0] op, input logic [3:0] amt,
                         input int hold, input bit noise, input string tag);
      logic [15:0] exp;
      int          exp_lat;
      int          lat;
      exp     = ref_shift(d, op, int'(amt));
      exp_lat = (op == 2'b00 || amt == 4'd0) ? 1 : int'(amt) + 1;
      @(negedge clk);
      check({tag, " in_ready_before"}, {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_op    = op;
      bus.in_amt   = amt;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 16'($urandom);
      lat = 1;
      while (!bus.out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " out_data"}, {16'd0, bus.out_data}, {16'd0, exp});
      check({tag, " out_zero"}, {31'd0, bus.out_zero}, {31'd0, (exp == 16'd0)});
      check({tag, " out_neg"}, {31'd0, bus.out_neg}, {31'd0, exp[15]});
      check({tag, " busy_done"}, {31'd0, busy}, 32'd1);
      for (int i = 0; i < hold; i++) begin
         if (noise) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'($urandom);
            bus.in_op    = 2'($urandom);
            bus.in_amt   = 4'($urandom);
         end
         @(negedge clk);
         check({tag, " held_data"}, {16'd0, bus.out_data}, {16'd0, exp});
         check({tag, " held_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      check({tag, " idle_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
      check({tag, " idle_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
      check({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      reset         = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 16'd0;
      bus.in_op     = 2'b00;
      bus.in_amt    = 4'd0;
      bus.out_ready = 1'b0;

      #12;
      check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("reset out_data", {16'd0, bus.out_data}, 32'd0);
      check("reset out_zero", {31'd0, bus.out_zero}, 32'd1);
      check("reset out_neg", {31'd0, bus.out_neg}, 32'd0);
      check("reset busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Basic LSL, ASR and a full-width LSR.
      do_req(16'h0001, 2'b01, 4'd4, 0, 1'b0, "lsl4");
      do_req(16'h8000, 2'b11, 4'd3, 0, 1'b0, "asr3");
      do_req(16'h8000, 2'b10, 4'd15, 0, 1'b0, "lsr15");

      // Bypass paths: zero amount and pass op.
      do_req(16'h1234, 2'b01, 4'd0, 0, 1'b0, "amt0");
      do_req(16'h1234, 2'b00, 4'd7, 0, 1'b0, "pass7");

      // Backpressure with concurrent requests that must be ignored; the
      // completing cycle also carries in_valid and must not accept it.
      do_req(16'h0001, 2'b01, 4'd4, 3, 1'b1, "bp");

      // Async reset mid-SHIFT.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'hA5A5;
      bus.in_op    = 2'b01;
      bus.in_amt   = 4'd8;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("pre_reset busy", {31'd0, busy}, 32'd1);
      #2 reset = 1'b1;
      #1;
      check("async_reset in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("async_reset out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("async_reset out_data", {16'd0, bus.out_data}, 32'd0);
      check("async_reset busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      do_req(16'h00FF, 2'b10, 4'd4, 0, 1'b0, "post_reset");

      // Flush while DONE with out_ready high: result is abandoned.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h0F0F;
      bus.in_op    = 2'b01;
      bus.in_amt   = 4'd2;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("pre_flush out_valid", {31'd0, bus.out_valid}, 32'd1);
      flush         = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      flush         = 1'b0;
      bus.out_ready = 1'b0;
      check("flush in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("flush out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("flush out_data", {16'd0, bus.out_data}, 32'd0);

      // Flush in IDLE drops a same-cycle request.
      bus.in_valid = 1'b1;
      flush        = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      flush        = 1'b0;
      check("flush_drop busy", {31'd0, busy}, 32'd0);

      // Width boundaries and zero flag.
      do_req(16'hFFFF, 2'b01, 4'd15, 0, 1'b0, "lsl15_ffff");
      do_req(16'h0001, 2'b01, 4'd15, 0, 1'b0, "lsl15_one");
      do_req(16'h8000, 2'b01, 4'd1, 0, 1'b0, "lsl1_top");
      do_req(16'h0001, 2'b10, 4'd1, 0, 1'b0, "lsr1_zero");
      do_req(16'h7FFF, 2'b11, 4'd15, 0, 1'b0, "asr15_pos");
      do_req(16'h8001, 2'b11, 4'd15, 0, 1'b0, "asr15_neg");

      // Randomized requests with random stalls.
      for (int i = 0; i < 60; i++) begin
         do_req(16'($urandom), 2'($urandom), 4'($urandom), int'($urandom_range(0, 3)),
                1'($urandom), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
